// File: rtl/sat_requant_pipe.sv
// Multi-lane two-stage requantiser: round/shift double-width products, then clamp to BIT_WIDTH.
// Valid/ready pipeline with a saturating count of clamped lanes.
module sat_requant_pipe #(
   parameter int unsigned BIT_WIDTH  = 16,
   parameter int unsigned FRAC_WIDTH = 8,
   parameter int unsigned LANES      = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [LANES*2*BIT_WIDTH-1:0]   in_data,
   input  logic [1:0]                     round_mode,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [LANES*BIT_WIDTH-1:0]     out_data,
   output logic [LANES-1:0]               out_sat,
   input  logic                           clr_stats,
   output logic [CNT_WIDTH-1:0]           sat_count
);

   localparam int unsigned IW = 2 * BIT_WIDTH;
   localparam int unsigned XW = IW + 1;
   localparam int unsigned PW = $clog2(LANES + 1);
   localparam int unsigned SW = CNT_WIDTH + 1;

   localparam logic [FRAC_WIDTH-1:0] HALF_F = FRAC_WIDTH'(1) << (FRAC_WIDTH - 1);
   localparam logic signed [XW-1:0]  HALF_S = XW'(HALF_F);
   localparam logic signed [XW-1:0]  ONE_S  = XW'(1);
   localparam logic signed [XW-1:0]  MAX_S  = {{(XW-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0]  MIN_S  = {{(XW-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};
   localparam logic [BIT_WIDTH-1:0]  OUT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
   localparam logic [BIT_WIDTH-1:0]  OUT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

   logic                        s1_valid;
   logic [LANES*XW-1:0]         s1_r;
   logic                        s1_en;
   logic                        s2_en;

   logic [LANES*XW-1:0]         rnd_d;
   logic signed [XW-1:0]        xe;
   logic signed [XW-1:0]        tr;
   logic signed [XW-1:0]        rr;
   logic [FRAC_WIDTH-1:0]       frac;

   logic [LANES*BIT_WIDTH-1:0]  clamp_d;
   logic [LANES-1:0]            sat_d;
   logic signed [XW-1:0]        rv;

   logic [PW-1:0]               pop;
   logic [CNT_WIDTH-1:0]        base;
   logic [SW-1:0]               sum;
   logic [CNT_WIDTH-1:0]        cnt_d;

   // Handshake: a stage advances when the stage after it is empty or draining.
   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = s1_en;

   // Stage 1 datapath: sign-extend one bit so the half-up carry can never wrap.
   always_comb begin
      rnd_d = '0;
      xe    = '0;
      tr    = '0;
      rr    = '0;
      frac  = '0;
      for (int i = 0; i < LANES; i++) begin
         xe   = {in_data[i*IW+IW-1], in_data[i*IW +: IW]};
         frac = in_data[i*IW +: FRAC_WIDTH];
         tr   = xe >>> FRAC_WIDTH;
         case (round_mode)
            2'd1:    rr = (xe + HALF_S) >>> FRAC_WIDTH;
            2'd2:    rr = ((frac > HALF_F) || ((frac == HALF_F) && tr[0])) ? tr + ONE_S : tr;
            default: rr = tr;
         endcase
         rnd_d[i*XW +: XW] = rr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_r     <= '0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_r <= rnd_d;
         end
      end
   end

   // Stage 2 datapath: clamp the full-width rounded value to the signed output range.
   always_comb begin
      clamp_d = '0;
      sat_d   = '0;
      rv      = '0;
      for (int i = 0; i < LANES; i++) begin
         rv = s1_r[i*XW +: XW];
         if (rv > MAX_S) begin
            clamp_d[i*BIT_WIDTH +: BIT_WIDTH] = OUT_MAX;
            sat_d[i]                          = 1'b1;
         end else if (rv < MIN_S) begin
            clamp_d[i*BIT_WIDTH +: BIT_WIDTH] = OUT_MIN;
            sat_d[i]                          = 1'b1;
         end else begin
            clamp_d[i*BIT_WIDTH +: BIT_WIDTH] = rv[BIT_WIDTH-1:0];
         end
      end
   end

   // Saturation statistic: a clear coinciding with a load restarts from that beat's count.
   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) begin
         pop = pop + PW'(sat_d[i]);
      end
      base  = clr_stats ? '0 : sat_count;
      sum   = {1'b0, base} + SW'(pop);
      cnt_d = sat_count;
      if (s2_en && s1_valid) begin
         cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      end else if (clr_stats) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= '0;
         sat_count <= '0;
      end else begin
         sat_count <= cnt_d;
         if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data <= clamp_d;
               out_sat  <= sat_d;
            end
         end
      end
   end

endmodule
